// File: rtl/ula_controlador_8b_if.sv
// Bundle of the command, ALU-side and result signals of the 8-bit ALU sequencer.
// Optional res_zero member exists only when ULA_CTRL_ZERO_FLAG_EN is defined.
interface ula_controlador_8b_if;
  // Handshake rule for cmd_* and res_*: a transfer happens on the rising edge where
  // valid and ready are both 1; the sender holds its payload stable while valid=1 and ready=0.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_s;
  logic       cmd_m;
  logic       cmd_cin;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_m;
  logic       alu_cin;
  logic [3:0] alu_f;
  logic       alu_cout;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_f;
  logic       res_cout;
  logic       res_equal;
`ifdef ULA_CTRL_ZERO_FLAG_EN
  logic       res_zero;
`endif

  // slave = the sequencer; master = command source, ALU instance and result consumer
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin,
    output cmd_ready,
    output alu_a, alu_b, alu_s, alu_m, alu_cin,
    input  alu_f, alu_cout,
    output res_valid, res_f, res_cout, res_equal,
`ifdef ULA_CTRL_ZERO_FLAG_EN
    output res_zero,
`endif
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s, alu_m, alu_cin,
    output alu_f, alu_cout,
    input  res_valid, res_f, res_cout, res_equal,
`ifdef ULA_CTRL_ZERO_FLAG_EN
    input  res_zero,
`endif
    output res_ready
  );
endinterface

// File: rtl/ula_controlador_8b.sv
// Sequencer running 8-bit commands as two chained nibble passes through an external 4-bit ALU.
// Define ULA_CTRL_ZERO_FLAG_EN to add the registered res_zero flag.
module ula_controlador_8b (
  input  logic                clk,
  input  logic                rst,
  ula_controlador_8b_if.slave bus,
  output logic [1:0]          state_dbg_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       cin;
  } alu_drv_t;

  // Maps one command nibble pass onto ALU inputs; inc/dec become add/sub against zero.
  function automatic alu_drv_t alu_drive(input logic [3:0] na, input logic [3:0] nb,
                                         input logic [3:0] s, input logic m,
                                         input logic first, input logic cmd_cin,
                                         input logic carry);
    alu_drv_t d;
    logic     chain;
    logic     step;
    chain = first ? cmd_cin : carry;
    step  = first ? 1'b1 : carry;
    d.a   = na;
    d.b   = nb;
    d.s   = s;
    d.m   = m;
    d.cin = 1'b0;
    if (m) begin
      case (s)
        4'd0, 4'd1, 4'd2: d.cin = chain;
        4'd3: begin d.s = 4'd0; d.b = 4'd0; d.cin = step; end
        4'd4: begin d.s = 4'd1; d.b = 4'd0; d.cin = step; end
        4'd5: begin d.s = 4'd0; d.a = nb; d.b = 4'd0; d.cin = step; end
        4'd6: begin d.s = 4'd1; d.a = nb; d.b = 4'd0; d.cin = step; end
        default: d.cin = 1'b0;
      endcase
    end
    return d;
  endfunction

  state_t     state_q;
  logic [3:0] a_hi_q;
  logic [3:0] b_hi_q;
  logic [3:0] s_q;
  logic       m_q;
  alu_drv_t   alu_q;
  logic [7:0] res_f_q;
  logic       res_cout_q;
  logic       res_equal_q;
  logic       res_valid_q;
  logic       cmd_ready_q;
`ifdef ULA_CTRL_ZERO_FLAG_EN
  logic       res_zero_q;
`endif

  alu_drv_t   alu_lo_d;
  alu_drv_t   alu_hi_d;
  logic       chained_op_d;

  assign alu_lo_d = alu_drive(bus.cmd_a[3:0], bus.cmd_b[3:0], bus.cmd_s, bus.cmd_m,
                              1'b1, bus.cmd_cin, 1'b0);
  // The low-pass carry feeds straight into the registered high-pass carry-in.
  assign alu_hi_d = alu_drive(a_hi_q, b_hi_q, s_q, m_q, 1'b0, 1'b0, bus.alu_cout);
  assign chained_op_d = m_q && (s_q <= 4'd6);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      alu_q       <= '0;
      res_f_q     <= '0;
      res_cout_q  <= 1'b0;
      res_equal_q <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
`ifdef ULA_CTRL_ZERO_FLAG_EN
      res_zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            a_hi_q      <= bus.cmd_a[7:4];
            b_hi_q      <= bus.cmd_b[7:4];
            s_q         <= bus.cmd_s;
            m_q         <= bus.cmd_m;
            res_equal_q <= (bus.cmd_a == bus.cmd_b);
            alu_q       <= alu_lo_d;
            cmd_ready_q <= 1'b0;
            state_q     <= LOW;
          end
        end
        LOW: begin
          res_f_q[3:0] <= bus.alu_f;
          alu_q        <= alu_hi_d;
          state_q      <= HIGH;
        end
        HIGH: begin
          res_f_q[7:4] <= bus.alu_f;
          res_cout_q   <= chained_op_d ? bus.alu_cout : 1'b0;
`ifdef ULA_CTRL_ZERO_FLAG_EN
          res_zero_q   <= ({bus.alu_f, res_f_q[3:0]} == 8'h00);
`endif
          alu_q        <= '0;
          res_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_a     = alu_q.a;
  assign bus.alu_b     = alu_q.b;
  assign bus.alu_s     = alu_q.s;
  assign bus.alu_m     = alu_q.m;
  assign bus.alu_cin   = alu_q.cin;
  assign bus.res_valid = res_valid_q;
  assign bus.res_f     = res_f_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_equal = res_equal_q;
`ifdef ULA_CTRL_ZERO_FLAG_EN
  assign bus.res_zero  = res_zero_q;
`endif
  assign state_dbg_o   = state_q;

endmodule
